osc_channel_scheduler: RTL and testbench
========================================

// Module: osc_channel_scheduler
// PURPOSE
// - Shares one 16-bit coupled sine/cosine update engine among NCH waveform channels.
// - Each channel has its own sine/cos state, rate divider and output mode (raw or full-wave rectified).
// - A round-robin arbiter grants due channels to the engine; 8-bit samples leave on a valid/ready stream.
// - Sits between the register/config interface and the DAC/sample sink of the lab wave generator.
// PARAMETERS
// - NCH      4      number of channels (2..8); channel index width CW = $clog2(NCH)
// - SHIFT    6      arithmetic right shift of the coupling term (sets frequency step)
// - INIT_AMP 30000  cos reset/reload value (signed 16-bit); sine reloads to 0
// - DIV_W    16     divider width
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      reset, asynchronous, active-high
// - start       in   1      pulse: set running; divider counters count from 0
// - stop        in   1      pulse: clear running and all pending; in-flight sample completes
// - cfg_we      in   1      config write strobe
// - cfg_ch      in   CW     channel addressed by cfg_we
// - cfg_div     in   DIV_W  tick period minus 1 (0 = due every cycle)
// - cfg_mode    in   1      0 = sample is sine[15:8]; 1 = full-wave rectified |sine[15:8]|
// - out_valid   out  1      sample available
// - out_ready   in   1      sink accepts the sample when out_valid & out_ready
// - out_ch      out  CW     channel of out_sample
// - out_sample  out  8      sample
// - busy        out  1      engine not in IDLE
// BEHAVIOUR
// - Reset: out_valid=0, out_ch=0, out_sample=0, busy=0, running=0, rr pointer=0; per channel:
//   sine=0, cos=INIT_AMP, div=0, mode=0, counter=0, pending=0.
// - Tick: while running, a channel's counter increments each cycle; at counter==div it wraps to 0 and
//   sets pending. A tick while the channel is already pending or in flight is dropped (overrun).
// - FSM: IDLE -> LOAD -> SIN -> COS -> EMIT -> IDLE.
//   IDLE: if any pending, grant the first pending channel at or after rr pointer; clear its pending;
//   rr pointer = granted+1 (mod NCH). LOAD: latch channel sine/cos into engine registers.
//   SIN: s' = s + (c >>> SHIFT). COS: c' = c - (s' >>> SHIFT) (uses new sine).
//   EMIT: out_valid=1; write back s', c'; stay until out_ready; then out_valid=0 and go to IDLE.
// - Latency: grant in IDLE -> out_valid asserted 4 cycles later; 5 cycles/sample minimum throughput.
// - Arithmetic: 16-bit two's complement; >>> sign-extends; sums wrap modulo 2^16 (no saturation).
// - Sample: raw = s'[15:8]. Rectified: raw if raw[7]=0, else -raw; raw=-128 yields 127 (saturated).
// - out_sample/out_ch stay stable while out_valid=1 and out_ready=0; write-back happens once, on entry to EMIT.
// - cfg_we: channel state reloads (sine=0, cos=INIT_AMP), counter=0, pending=0, div/mode updated.
//   If the channel is in flight, its write-back is suppressed and the emitted sample is still delivered.
//   cfg_we coincident with a tick of the same channel: config wins, no pending set.
// - start and stop both asserted: stop wins. stop mid-FSM: current sample runs to handshake completion.
// - rst mid-operation: immediate return to reset values; an unaccepted sample is lost.
// CONFIGURATION
// - OSC_OVERRUN_EN defined: adds output overrun [NCH-1:0]. Sticky bit per channel, set on a dropped
//   tick, cleared by cfg_we to that channel or by rst. Reset value 0.
// - OSC_OVERRUN_EN undefined: no overrun port; dropped ticks are discarded silently.
// TESTING
// - rst; cfg ch0 div=0 mode=0; start; out_ready=1 -> first sample ch0 = 8'd1 (s'=468, c'=29993),
//   second = 8'd3 (s'=936).
// - All 4 channels div=0, out_ready=1 -> out_ch sequence 0,1,2,3,0,1; each sample spaced 5 cycles.
// - ch0 mode=1 div=0, run 500 samples -> every out_sample in 0..117; raw mode same run shows
//   negative values down to about -118.
// - out_ready=0 for 12 cycles during EMIT -> out_valid, out_ch, out_sample constant; ch0 (div=0)
//   overrun=1 with OSC_OVERRUN_EN; cfg_we ch0 clears it.
// - cfg_we to in-flight ch1 during SIN -> sample still emitted; next ch1 sample = 8'd1 (state reloaded).
// - Assert rst during COS -> next cycle out_valid=0, busy=0; after start, ch0 first sample = 8'd1.

Source files
------------

// File: rtl/osc_channel_scheduler.sv
// osc_channel_scheduler
//   One 16-bit coupled sine/cosine update engine shared by NCH waveform
//   channels. Each channel keeps its own sine/cos state, rate divider and
//   output mode. Due channels are granted round-robin. 8-bit samples leave
//   on a valid/ready stream.
//
// Build option
//   OSC_OVERRUN_EN : adds the 'overrun' output. It holds one sticky bit per
//                    channel, set when a tick is dropped. Without it, dropped
//                    ticks are discarded silently.
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start        pulse: set running, restart all divider counters at 0
//   stop         pulse: clear running and every pending flag (wins over start)
//   cfg_we       config strobe for channel cfg_ch: reload its sine/cos,
//                clear counter/pending, update cfg_div / cfg_mode
//   cfg_div      tick period minus 1 (0 = due every cycle)
//   cfg_mode     0 = raw sine[15:8], 1 = full-wave rectified
//   out_valid    sample available          out_ready  sink accepts it
//   out_ch       channel of out_sample     out_sample 8-bit sample
//   busy         engine not idle
//   o_dbg_state  current engine FSM state (IDLE=0 LOAD=1 SIN=2 COS=3 EMIT=4)
//   overrun      (OSC_OVERRUN_EN only) sticky dropped-tick flag per channel
//
// Stream handshake: out_valid rises when EMIT is entered. out_ch and
// out_sample hold steady until the cycle in which out_valid & out_ready are
// both high. The sample transfers on that rising edge. out_valid never drops
// before the transfer, except on rst.
module osc_channel_scheduler #(
    parameter int                 NCH      = 4,
    parameter int                 SHIFT    = 6,
    parameter logic signed [15:0] INIT_AMP = 16'sd30000,
    parameter int                 DIV_W    = 16,
    localparam int                CW       = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_ch,
    output logic [7:0]       out_sample,
    output logic             busy,
`ifdef OSC_OVERRUN_EN
    output logic [NCH-1:0]   overrun,
`endif
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SIN  = 3'd2,
        S_COS  = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic               r_running;
    logic [CW-1:0]      r_rr, r_ch, r_out_ch;
    logic [7:0]         r_out_sample;
    logic               r_kill;          // in-flight channel was reconfigured
    logic signed [15:0] r_s, r_c;

    logic signed [15:0] r_sin [NCH];
    logic signed [15:0] r_cos [NCH];
    logic [DIV_W-1:0]   r_div [NCH];
    logic [DIV_W-1:0]   r_cnt [NCH];
    logic [NCH-1:0]     r_mode, r_pending;

    logic [NCH-1:0]     w_tick, w_cfg_hit, w_in_flight;
    logic               w_grant_valid;
    logic [CW-1:0]      w_grant_ch, w_rr_next;
    logic signed [15:0] w_s_next, w_c_next;
    logic [7:0]         w_raw, w_sample;
    logic               w_start_go, w_cfg_on_engine, w_wb_en, w_grant_take;

    assign w_start_go      = start && !stop;
    assign w_cfg_on_engine = cfg_we && (cfg_ch == r_ch);
    assign w_grant_take    = (r_state == S_IDLE) && w_grant_valid;

    always_comb begin
        w_tick      = '0;
        w_cfg_hit   = '0;
        w_in_flight = '0;
        for (int i = 0; i < NCH; i++) begin
            w_tick[i]      = r_running && (r_cnt[i] == r_div[i]);
            w_cfg_hit[i]   = cfg_we && (cfg_ch == CW'(i));
            w_in_flight[i] = (r_state != S_IDLE) && (r_ch == CW'(i));
        end
    end

    // Round-robin: scan from the far end back toward r_rr, so the pending
    // channel closest to r_rr (inclusive) is the one left standing.
    always_comb begin
        logic [CW:0] v_idx;
        logic [CW:0] v_nxt;
        v_idx         = '0;
        v_nxt         = '0;
        w_grant_valid = 1'b0;
        w_grant_ch    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr} + (CW + 1)'(k);
            if (v_idx >= (CW + 1)'(NCH))
                v_idx = v_idx - (CW + 1)'(NCH);
            if (r_pending[v_idx[CW-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_ch    = v_idx[CW-1:0];
            end
        end
        v_nxt = {1'b0, w_grant_ch} + (CW + 1)'(1);
        if (v_nxt == (CW + 1)'(NCH))
            v_nxt = '0;
        w_rr_next = v_nxt[CW-1:0];
    end

    // In SIN, r_s still holds the old sine. In COS, r_s already holds s',
    // so the cosine update uses the new sine.
    assign w_s_next = r_s + (r_c >>> SHIFT);
    assign w_c_next = r_c - (r_s >>> SHIFT);
    assign w_raw    = r_s[15:8];

    always_comb begin
        w_sample = w_raw;
        if (r_mode[r_ch] && w_raw[7]) begin
            if (w_raw == 8'h80)
                w_sample = 8'h7F;                  // |-128| saturates
            else
                w_sample = 8'(~w_raw + 8'd1);
        end
    end

    // Write-back happens once, on the COS -> EMIT edge, unless the channel
    // was reconfigured while in flight.
    assign w_wb_en = (r_state == S_COS) && !r_kill && !w_cfg_on_engine;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_valid) w_next = S_LOAD;
            S_LOAD:  w_next = S_SIN;
            S_SIN:   w_next = S_COS;
            S_COS:   w_next = S_EMIT;
            S_EMIT:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr         <= '0;
            r_ch         <= '0;
            r_kill       <= 1'b0;
            r_s          <= '0;
            r_c          <= '0;
            r_out_ch     <= '0;
            r_out_sample <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_ch   <= w_grant_ch;
                        r_rr   <= w_rr_next;
                        r_kill <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_s <= r_sin[r_ch];
                    r_c <= r_cos[r_ch];
                    if (w_cfg_on_engine) r_kill <= 1'b1;
                end
                S_SIN: begin
                    r_s <= w_s_next;
                    if (w_cfg_on_engine) r_kill <= 1'b1;
                end
                S_COS: begin
                    r_c          <= w_c_next;
                    r_out_ch     <= r_ch;
                    r_out_sample <= w_sample;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_running <= 1'b0;
        else if (stop)       r_running <= 1'b0;
        else if (w_start_go) r_running <= 1'b1;
    end

    // Per-channel state. A config write beats anything else that happens to
    // the same channel in that cycle, including a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_sin[i]     <= '0;
                r_cos[i]     <= INIT_AMP;
                r_div[i]     <= '0;
                r_cnt[i]     <= '0;
                r_mode[i]    <= 1'b0;
                r_pending[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_cfg_hit[i]) begin
                    r_sin[i]     <= '0;
                    r_cos[i]     <= INIT_AMP;
                    r_div[i]     <= cfg_div;
                    r_mode[i]    <= cfg_mode;
                    r_cnt[i]     <= '0;
                    r_pending[i] <= 1'b0;
                end else begin
                    if (w_start_go)
                        r_cnt[i] <= '0;
                    else if (r_running)
                        r_cnt[i] <= w_tick[i] ? '0 : r_cnt[i] + 1'b1;

                    // A tick that lands while pending or in flight is lost.
                    if (stop)
                        r_pending[i] <= 1'b0;
                    else if (w_grant_take && (w_grant_ch == CW'(i)))
                        r_pending[i] <= 1'b0;
                    else if (w_tick[i] && !w_in_flight[i])
                        r_pending[i] <= 1'b1;

                    if (w_wb_en && (r_ch == CW'(i))) begin
                        r_sin[i] <= r_s;
                        r_cos[i] <= w_c_next;
                    end
                end
            end
        end
    end

`ifdef OSC_OVERRUN_EN
    logic [NCH-1:0] r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_cfg_hit[i])
                    r_overrun[i] <= 1'b0;
                else if (w_tick[i] && (r_pending[i] || w_in_flight[i]))
                    r_overrun[i] <= 1'b1;
            end
        end
    end

    assign overrun = r_overrun;
`else
    // Dropped ticks leave no trace in this build.
`endif

    assign out_valid   = (r_state == S_EMIT);
    assign busy        = (r_state != S_IDLE);
    assign out_ch      = r_out_ch;
    assign out_sample  = r_out_sample;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_osc_channel_scheduler.sv
module tb_osc_channel_scheduler;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int W   = CW + 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             cfg_we;
  logic [CW-1:0]    cfg_ch;
  logic [15:0]      cfg_div;
  logic             cfg_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_ch;
  logic [7:0]       out_sample;
  logic             busy;
  logic [2:0]       dbg_state;
`ifdef OSC_OVERRUN_EN
  logic [NCH-1:0]   overrun;
`endif

  osc_channel_scheduler #(.NCH(NCH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_sample  (out_sample),
    .busy        (busy),
`ifdef OSC_OVERRUN_EN
    .overrun     (overrun),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           hs_cyc_q[$];
  logic [7:0]   hs_val_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pops one expectation per accepted sample; samples between edges.
  task automatic monitor();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        act = {out_ch, out_sample};
        hs_cyc_q.push_back(cyc);
        hs_val_q.push_back(out_sample);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample actual=0x%0h expected=none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL sample actual=0x%0h expected=0x%0h (ch<<8|sample)", act, exp);
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    hs_cyc_q.delete();
    hs_val_q.delete();
  endtask

  task automatic cfg_write(input int ch, input logic [15:0] div, input logic mode);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_div = div; cfg_mode = mode;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic exp_push(input int ch, input logic [7:0] smp);
    exp_q.push_back({CW'(ch), smp});
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d_left expected=0_left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == st) begin ok = 1; break; end
      tick();
    end
    check(name, ok, 1);
  endtask

  // Spec-level arithmetic of one engine pass.
  task automatic model_next(input logic signed [15:0] s_in, input logic signed [15:0] c_in,
                            input logic mode, output logic signed [15:0] s_out,
                            output logic signed [15:0] c_out, output logic [7:0] smp);
    logic [7:0] raw;
    s_out = s_in + (c_in >>> 6);
    c_out = c_in - (s_out >>> 6);
    raw = s_out[15:8];
    smp = raw;
    if (mode && raw[7]) smp = (raw == 8'h80) ? 8'h7F : 8'(-raw);
  endtask

  task automatic quiet_others(input int keep);
    for (int ch = 0; ch < NCH; ch++)
      if (ch != keep) cfg_write(ch, 16'hFFFF, 1'b0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t0, viol, vmax, vmin, ok;
    logic signed [15:0] ms, mc;
    logic [7:0] msmp, v0s;
    logic [CW-1:0] v0c;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0; out_ready = 1'b0;
    fork monitor(); join_none

    // reset values
    tick(); tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_ch", int'(out_ch), 0);
    check("rst_sample", int'(out_sample), 0);
    check("rst_busy", int'(busy), 0);
`ifdef OSC_OVERRUN_EN
    check("rst_overrun", int'(overrun), 0);
`endif

    // single channel ch0: samples 1,3,5,7 and latency from start
    do_reset();
    quiet_others(0);
    cfg_write(0, 16'd0, 1'b0);
    exp_push(0, 8'd1); exp_push(0, 8'd3); exp_push(0, 8'd5); exp_push(0, 8'd7);
    out_ready = 1'b1;
    t0 = cyc;
    pulse_start();
    wait_drain(200, "t1");
    out_ready = 1'b0;
    if (hs_cyc_q.size() > 0) check("t1_latency", hs_cyc_q[0] - t0, 6);
    else check("t1_latency_none", 0, 1);

    // four channels, all due every cycle: 0,1,2,3,0,1,2,3 spaced 5 cycles
    do_reset();
    for (int ch = 0; ch < NCH; ch++) exp_push(ch, 8'd1);
    for (int ch = 0; ch < NCH; ch++) exp_push(ch, 8'd3);
    out_ready = 1'b1;
    pulse_start();
    wait_drain(200, "t2");
    out_ready = 1'b0;
    for (int i = 1; i < 8; i++)
      if (i < hs_cyc_q.size()) check("t2_spacing", hs_cyc_q[i] - hs_cyc_q[i-1], 5);

    // long runs: rectified then raw, exact values from the arithmetic model
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      quiet_others(0);
      cfg_write(0, 16'd0, 1'(m));
      ms = 16'sd0; mc = 16'sd30000;
      for (int i = 0; i < 500; i++) begin
        model_next(ms, mc, 1'(m), ms, mc, msmp);
        exp_push(0, msmp);
      end
      out_ready = 1'b1;
      pulse_start();
      wait_drain(3300, m ? "t3_rect" : "t3_raw");
      out_ready = 1'b0;
      viol = 0; vmax = -200; vmin = 200;
      for (int i = 0; i < hs_val_q.size(); i++) begin
        if ($signed(hs_val_q[i]) > vmax) vmax = $signed(hs_val_q[i]);
        if ($signed(hs_val_q[i]) < vmin) vmin = $signed(hs_val_q[i]);
        if (hs_val_q[i][7]) viol++;
      end
      if (m == 1) begin
        check("t3_rect_nonneg", viol, 0);
        check("t3_rect_peak", int'(vmax >= 110), 1);
      end else begin
        check("t3_raw_neg_peak", int'(vmin <= -110), 1);
      end
    end

    // stall in EMIT for 12 cycles, stop mid-flight, then accept
    do_reset();
    quiet_others(0);
    cfg_write(0, 16'd0, 1'b0);
    exp_push(0, 8'd1);
    pulse_start();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    check("t4_valid_seen", ok, 1);
    v0c = out_ch; v0s = out_sample;
    check("t4_ch", int'(v0c), 0);
    check("t4_sample", int'(v0s), 1);
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!out_valid || out_ch !== v0c || out_sample !== v0s) viol++;
    end
    check("t4_stable", viol, 0);
    tick();
`ifdef OSC_OVERRUN_EN
    check("t4_overrun_set", int'(overrun[0]), 1);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_valid_after_stop", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_drain(20, "t4");
    repeat (20) tick();
    check("t4_busy_after_stop", int'(busy), 0);
    check("t4_valid_after_stop_done", int'(out_valid), 0);
`ifdef OSC_OVERRUN_EN
    cfg_write(0, 16'd0, 1'b0);
    @(negedge clk);
    check("t4_overrun_clr", int'(overrun[0]), 0);
    tick();
`endif
    out_ready = 1'b0;

    // reconfigure ch1 while it is in SIN: sample delivered, state reloaded
    do_reset();
    quiet_others(1);
    exp_push(1, 8'd1); exp_push(1, 8'd1);
    out_ready = 1'b1;
    pulse_start();
    wait_state(3'd2, 50, "t5_reach_sin");
    cfg_write(1, 16'd0, 1'b0);
    wait_drain(100, "t5");
    out_ready = 1'b0;

    // reset during COS: immediate idle, then a clean restart
    do_reset();
    quiet_others(0);
    out_ready = 1'b1;
    pulse_start();
    wait_state(3'd3, 50, "t6_reach_cos");
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", int'(out_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_state", int'(dbg_state), 0);
    tick();
    rst = 1'b0;
    tick();
    quiet_others(0);
    exp_push(0, 8'd1);
    pulse_start();
    wait_drain(100, "t6");
    out_ready = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
